// File: rtl/matmul_pkg.sv
// Shared types and helpers for the parametrised matrix-multiply controller:
// FSM state encoding, index-width derivation and accumulator saturation.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int SAT_W = 64;

    // One spare code point above N*N-1 so out-of-range indices can be presented and rejected.
    function automatic int idx_width(input int n);
        return $clog2(n * n + 1);
    endfunction

    // Clamp an acc_w-bit accumulator (zero-extended into SAT_W bits) to data_w bits.
    function automatic logic [SAT_W-1:0] sat_to_data(
        input logic [SAT_W-1:0] acc,
        input int               acc_w,
        input int               data_w,
        input logic             is_signed
    );
        logic             neg;
        logic             ovf;
        logic [SAT_W-1:0] lim;
        logic [SAT_W-1:0] res;
        neg = acc[acc_w-1];
        ovf = 1'b0;
        for (int b = 0; b < SAT_W; b++) begin
            if (is_signed) begin
                if (b >= data_w - 1 && b < acc_w && acc[b] != neg) ovf = 1'b1;
            end else begin
                if (b >= data_w && b < acc_w && acc[b]) ovf = 1'b1;
            end
        end
        lim = SAT_W'(1) << (data_w - 1);
        if (!ovf)
            res = acc;
        else if (is_signed)
            res = neg ? lim : lim - SAT_W'(1);
        else
            res = (lim << 1) - SAT_W'(1);
        return res;
    endfunction

endpackage

// File: rtl/matmul_ctrl_n_if.sv
// Load / read-back bus between the host top level and the matrix controller.
interface matmul_ctrl_n_if #(
    parameter int N      = 2,
    parameter int DATA_W = 8
);
    import matmul_pkg::*;

    localparam int IDX_W = idx_width(N);

    logic              load_en;
    logic              load_sel_ab;
    logic [IDX_W-1:0]  load_index;
    logic [DATA_W-1:0] in_data;
    logic              signed_mode;
    logic              acc_mode;
    logic              output_en;
    logic [IDX_W-1:0]  output_sel;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;

    modport master (
        output load_en, load_sel_ab, load_index, in_data,
        output signed_mode, acc_mode, output_en, output_sel,
        input  out_data, busy, done
    );

    modport slave (
        input  load_en, load_sel_ab, load_index, in_data,
        input  signed_mode, acc_mode, output_en, output_sel,
        output out_data, busy, done
    );

endinterface

// File: rtl/mac_unit.sv
// Combinational extend-multiply-add; kept separate so a systolic array can replace it.
module mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  base,
    input  logic              signed_mode,
    output logic [ACC_W-1:0]  sum
);
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;

    assign a_ext = {{(ACC_W-DATA_W){signed_mode & a[DATA_W-1]}}, a};
    assign b_ext = {{(ACC_W-DATA_W){signed_mode & b[DATA_W-1]}}, b};
    // Product is taken modulo 2^ACC_W, which is exact after extension to ACC_W.
    assign sum   = base + a_ext * b_ext;

endmodule

// File: rtl/matmul_ctrl_n.sv
// N x N matrix controller: element-wise operand load, sequential MAC over i/j/k,
// saturated read-back of C with optional accumulation across runs.
module matmul_ctrl_n
    import matmul_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic           clk,
    input  logic           rst,
    matmul_ctrl_n_if.slave bus
);
    localparam int NN    = N * N;
    localparam int IDX_W = idx_width(N);
    localparam int AW    = $clog2(NN);
    localparam int CW    = $clog2(N);

    state_t            state_reg, state_next;
    logic [NN-1:0]     loaded_a_reg, loaded_a_next;
    logic [NN-1:0]     loaded_b_reg, loaded_b_next;
    logic              signed_reg, signed_next;
    logic              acc_mode_reg, acc_mode_next;
    logic [CW-1:0]     i_reg, i_next, j_reg, j_next, k_reg, k_next;
    logic [DATA_W-1:0] out_data_reg, out_data_next;

    logic [DATA_W-1:0] a_mem [NN];
    logic [DATA_W-1:0] b_mem [NN];
    logic [ACC_W-1:0]  c_mem [NN];

    logic              a_we, b_we, c_we;
    logic              load_ok, out_ok;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [AW-1:0]     a_addr, b_addr, c_addr;
    logic [ACC_W-1:0]  mac_base, mac_sum;

    assign load_ok = bus.load_index < IDX_W'(NN);
    assign out_ok  = bus.output_sel < IDX_W'(NN);
    assign wr_addr = bus.load_index[AW-1:0];
    assign rd_addr = bus.output_sel[AW-1:0];
    assign a_addr  = AW'(int'(i_reg) * N + int'(k_reg));
    assign b_addr  = AW'(int'(k_reg) * N + int'(j_reg));
    assign c_addr  = AW'(int'(i_reg) * N + int'(j_reg));

    // First k of a non-accumulating run starts from zero instead of the stored C.
    assign mac_base = (k_reg == '0 && !acc_mode_reg) ? '0 : c_mem[c_addr];

    mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .a           (a_mem[a_addr]),
        .b           (b_mem[b_addr]),
        .base        (mac_base),
        .signed_mode (signed_reg),
        .sum         (mac_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_LOAD;
            loaded_a_reg <= '0;
            loaded_b_reg <= '0;
            signed_reg   <= 1'b0;
            acc_mode_reg <= 1'b0;
            i_reg        <= '0;
            j_reg        <= '0;
            k_reg        <= '0;
            out_data_reg <= '0;
            for (int e = 0; e < NN; e++) begin
                a_mem[e] <= '0;
                b_mem[e] <= '0;
                c_mem[e] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            loaded_a_reg <= loaded_a_next;
            loaded_b_reg <= loaded_b_next;
            signed_reg   <= signed_next;
            acc_mode_reg <= acc_mode_next;
            i_reg        <= i_next;
            j_reg        <= j_next;
            k_reg        <= k_next;
            out_data_reg <= out_data_next;
            if (a_we) a_mem[wr_addr] <= bus.in_data;
            if (b_we) b_mem[wr_addr] <= bus.in_data;
            if (c_we) c_mem[c_addr]  <= mac_sum;
        end
    end

    always_comb begin
        state_next    = state_reg;
        loaded_a_next = loaded_a_reg;
        loaded_b_next = loaded_b_reg;
        signed_next   = signed_reg;
        acc_mode_next = acc_mode_reg;
        i_next        = i_reg;
        j_next        = j_reg;
        k_next        = k_reg;
        out_data_next = out_data_reg;
        a_we          = 1'b0;
        b_we          = 1'b0;
        c_we          = 1'b0;

        case (state_reg)
            ST_LOAD: begin
                if (&loaded_a_reg && &loaded_b_reg) begin
                    state_next    = ST_COMPUTE;
                    signed_next   = bus.signed_mode;
                    acc_mode_next = bus.acc_mode;
                    loaded_a_next = '0;
                    loaded_b_next = '0;
                    i_next        = '0;
                    j_next        = '0;
                    k_next        = '0;
                end else if (bus.load_en && load_ok) begin
                    a_we = !bus.load_sel_ab;
                    b_we = bus.load_sel_ab;
                end
            end
            ST_COMPUTE: begin
                c_we = 1'b1;
                if (k_reg != CW'(N - 1)) begin
                    k_next = k_reg + CW'(1);
                end else begin
                    k_next = '0;
                    if (j_reg != CW'(N - 1)) begin
                        j_next = j_reg + CW'(1);
                    end else begin
                        j_next = '0;
                        if (i_reg != CW'(N - 1)) i_next = i_reg + CW'(1);
                        else state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.load_en) begin
                    state_next = ST_LOAD;
                    a_we = load_ok && !bus.load_sel_ab;
                    b_we = load_ok && bus.load_sel_ab;
                end
            end
            default: state_next = ST_LOAD;
        endcase

        if (a_we) loaded_a_next = loaded_a_reg | (NN'(1) << wr_addr);
        if (b_we) loaded_b_next = loaded_b_reg | (NN'(1) << wr_addr);

        if (state_reg != ST_COMPUTE && bus.output_en && out_ok)
            out_data_next = DATA_W'(sat_to_data(SAT_W'(c_mem[rd_addr]), ACC_W, DATA_W, signed_reg));
    end

    assign bus.out_data = out_data_reg;
    assign bus.busy     = (state_reg == ST_COMPUTE);
    assign bus.done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_matmul_ctrl_n.sv
// Randomised bench for matmul_ctrl_n: directed scenarios plus random runs checked
// against a plain-arithmetic matrix model of A*B with saturation and accumulation.
module tb_matmul_ctrl_n;
    import matmul_pkg::*;

    localparam int N      = 2;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;
    localparam int NN     = N * N;
    localparam int IDX_W  = idx_width(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_ctrl_n_if #(.N(N), .DATA_W(DATA_W)) bus ();

    matmul_ctrl_n #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    longint m_a [NN];
    longint m_b [NN];
    longint m_c [NN];
    bit     m_sgn;

    longint s1_a [NN] = '{1, 2, 3, 4};
    longint s1_b [NN] = '{5, 6, 7, 8};
    longint s2_a [NN] = '{-1, 2, 3, -4};
    longint s2_b [NN] = '{5, -6, 7, 8};
    longint all_127 [NN] = '{127, 127, 127, 127};
    longint all_m128 [NN] = '{-128, -128, -128, -128};
    longint ident [NN] = '{1, 0, 0, 1};
    longint r_a [NN];
    longint r_b [NN];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint ext(input longint v, input bit sgn);
        longint x;
        x = v & ((longint'(1) << DATA_W) - 1);
        if (sgn && x >= (longint'(1) << (DATA_W - 1))) x -= (longint'(1) << DATA_W);
        return x;
    endfunction

    task automatic model_compute(input bit sgn, input bit accm);
        longint s;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                s = accm ? m_c[r*N+c] : 0;
                for (int k = 0; k < N; k++)
                    s += ext(m_a[r*N+k], sgn) * ext(m_b[k*N+c], sgn);
                m_c[r*N+c] = s & ((longint'(1) << ACC_W) - 1);
            end
        m_sgn = sgn;
    endtask

    function automatic longint model_sat(input int idx);
        longint v, lo, hi;
        v = m_c[idx];
        if (m_sgn) begin
            if (v >= (longint'(1) << (ACC_W - 1))) v -= (longint'(1) << ACC_W);
            lo = -(longint'(1) << (DATA_W - 1));
            hi = (longint'(1) << (DATA_W - 1)) - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) << DATA_W) - 1;
        end
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        return v & ((longint'(1) << DATA_W) - 1);
    endfunction

    task automatic model_reset();
        for (int e = 0; e < NN; e++) begin
            m_a[e] = 0;
            m_b[e] = 0;
            m_c[e] = 0;
        end
        m_sgn = 1'b0;
    endtask

    task automatic write_elem(input bit ab, input int idx, input longint val);
        bus.load_en     = 1'b1;
        bus.load_sel_ab = ab;
        bus.load_index  = IDX_W'(idx);
        bus.in_data     = DATA_W'(val);
        tick();
        bus.load_en = 1'b0;
        if (idx < NN) begin
            if (ab) m_b[idx] = val & ((longint'(1) << DATA_W) - 1);
            else    m_a[idx] = val & ((longint'(1) << DATA_W) - 1);
        end
    endtask

    // Called right after the edge that wrote the last missing element.
    task automatic wait_compute(input bit disturb);
        int edges = 0;
        int first = 0;
        int nbusy = 0;
        int done_at = 0;
        logic [DATA_W-1:0] held;
        held = bus.out_data;
        while (done_at == 0 && edges < 200) begin
            tick();
            edges++;
            if (bus.busy) begin
                nbusy++;
                if (first == 0) first = edges;
            end
            if (bus.done) done_at = edges;
            if (disturb && bus.busy) begin
                check("out_hold_compute", bus.out_data, held);
                bus.load_en     = 1'b1;
                bus.load_sel_ab = 1'($urandom_range(0, 1));
                bus.load_index  = IDX_W'($urandom_range(0, NN - 1));
                bus.in_data     = DATA_W'($urandom);
                bus.output_en   = 1'b1;
                bus.output_sel  = IDX_W'($urandom_range(0, NN - 1));
            end else begin
                bus.load_en   = 1'b0;
                bus.output_en = 1'b0;
            end
        end
        bus.load_en   = 1'b0;
        bus.output_en = 1'b0;
        check("busy_start_edge", first, 1);
        check("busy_cycles", nbusy, N * N * N);
        check("done_edge", done_at, N * N * N + 1);
        model_compute(bus.signed_mode, bus.acc_mode);
        $display("compute signed=%0b acc=%0b done after %0d edges", bus.signed_mode, bus.acc_mode, done_at);
    endtask

    task automatic load_all(input longint a[NN], input longint b[NN], input bit junk, input bit disturb);
        int ord [2*NN];
        int tmp, sw, e, idx;
        bit ab;
        for (int p = 0; p < 2 * NN; p++) ord[p] = p;
        for (int p = 2 * NN - 1; p > 0; p--) begin
            sw = $urandom_range(0, p);
            tmp = ord[p];
            ord[p] = ord[sw];
            ord[sw] = tmp;
        end
        for (int p = 0; p < 2 * NN; p++) begin
            e   = ord[p];
            ab  = (e >= NN);
            idx = e % NN;
            if (junk && p < 2 * NN - 1 && $urandom_range(0, 1) == 1)
                write_elem(ab, idx, longint'($urandom_range(0, 255)));
            if (junk && p < 2 * NN - 1 && $urandom_range(0, 3) == 0)
                write_elem(1'($urandom_range(0, 1)), int'($urandom_range(NN, (1 << IDX_W) - 1)),
                           longint'($urandom_range(0, 255)));
            write_elem(ab, idx, ab ? b[idx] : a[idx]);
        end
        wait_compute(disturb);
    endtask

    task automatic read_all(input string tag);
        longint exp;
        for (int idx = 0; idx < NN; idx++) begin
            bus.output_en  = 1'b1;
            bus.output_sel = IDX_W'(idx);
            tick();
            bus.output_en = 1'b0;
            exp = model_sat(idx);
            $display("read %s c[%0d] = %0d (expect %0d)", tag, idx, bus.out_data, exp);
            check($sformatf("%s_c%0d", tag, idx), bus.out_data, exp);
        end
        tick();
        check($sformatf("%s_hold", tag), bus.out_data, model_sat(NN - 1));
    endtask

    initial begin
        int nb;
        bus.load_en     = 1'b0;
        bus.load_sel_ab = 1'b0;
        bus.load_index  = '0;
        bus.in_data     = '0;
        bus.signed_mode = 1'b0;
        bus.acc_mode    = 1'b0;
        bus.output_en   = 1'b0;
        bus.output_sel  = '0;
        model_reset();
        rst = 1'b1;
        repeat (2) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_out", bus.out_data, 0);
        rst = 1'b0;
        tick();

        // Unsigned product, then accumulate, then plain again
        load_all(s1_a, s1_b, 1'b0, 1'b0);
        read_all("unsigned");
        bus.acc_mode = 1'b1;
        load_all(s1_a, s1_b, 1'b0, 1'b0);
        read_all("accumulate");
        bus.acc_mode = 1'b0;
        load_all(s1_a, s1_b, 1'b0, 1'b0);
        read_all("reload");

        bus.signed_mode = 1'b1;
        load_all(s2_a, s2_b, 1'b0, 1'b0);
        read_all("signed");

        // Saturation
        bus.signed_mode = 1'b0;
        load_all(all_127, all_127, 1'b0, 1'b0);
        read_all("sat_u127");
        bus.signed_mode = 1'b1;
        load_all(all_127, all_127, 1'b0, 1'b0);
        read_all("sat_s127");
        load_all(all_m128, all_127, 1'b0, 1'b0);
        read_all("sat_sneg");

        // Out-of-range index, duplicate writes, traffic during compute
        bus.signed_mode = 1'b0;
        for (int e = 0; e < NN; e++) write_elem(1'b0, e, s1_a[e]);
        for (int e = 0; e < NN - 1; e++) write_elem(1'b1, e, s1_b[e]);
        write_elem(1'b0, 5, 99);
        write_elem(1'b1, 5, 99);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("oor_no_start", bus.busy, 0);
        end
        write_elem(1'b1, 0, 77);
        write_elem(1'b1, 0, s1_b[0]);
        check("dup_no_start", bus.busy, 0);
        write_elem(1'b1, NN - 1, s1_b[NN-1]);
        wait_compute(1'b1);
        read_all("protocol");

        // Output select out of range holds
        bus.output_en  = 1'b1;
        bus.output_sel = IDX_W'(5);
        tick();
        bus.output_en = 1'b0;
        check("oor_read_hold", bus.out_data, model_sat(NN - 1));

        // Reset in the middle of COMPUTE
        for (int e = 0; e < NN; e++) write_elem(1'b0, e, s2_a[e]);
        for (int e = 0; e < NN; e++) write_elem(1'b1, e, s2_b[e]);
        nb = 0;
        for (int c = 0; c < 50 && nb < 4; c++) begin
            tick();
            if (bus.busy) nb++;
        end
        check("busy_before_rst", nb, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_out", bus.out_data, 0);
        bus.output_en  = 1'b1;
        bus.output_sel = '0;
        tick();
        bus.output_en = 1'b0;
        check("midrst_c0", bus.out_data, 0);
        load_all(ident, s1_b, 1'b0, 1'b0);
        read_all("after_rst");

        // Random runs with junk writes, mode mixes and compute-time traffic
        for (int it = 0; it < 12; it++) begin
            for (int e = 0; e < NN; e++) begin
                r_a[e] = (it % 4 == 3) ? longint'($urandom_range(120, 255)) : longint'($urandom_range(0, 255));
                r_b[e] = (it % 4 == 3) ? longint'($urandom_range(120, 255)) : longint'($urandom_range(0, 255));
            end
            bus.signed_mode = 1'($urandom_range(0, 1));
            bus.acc_mode    = 1'($urandom_range(0, 1));
            load_all(r_a, r_b, 1'b1, 1'b1);
            read_all($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
